// File: rtl/axi_stream_burst_writer_pkg.sv
// Shared types and helpers for the stream-to-AXI burst writer.
package axi_burst_pkg;

  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

  function automatic logic [31:0] beats_to_bytes(input logic [15:0] len, input int d_level);
    return 32'(len) << d_level;
  endfunction

endpackage

// File: rtl/axi_stream_burst_writer_if.sv
// Stream input plus AXI AW/W/B write channels of the burst writer.
interface axi_stream_burst_writer_if #(
  parameter int A_WIDTH = 25,
  parameter int D_WIDTH = 16
);
  logic               s_valid;
  logic               s_ready;
  logic [D_WIDTH-1:0] s_data;

  logic               awvalid;
  logic               awready;
  logic [A_WIDTH-1:0] awaddr;
  logic [7:0]         awlen;

  logic               wvalid;
  logic               wready;
  logic               wlast;
  logic [D_WIDTH-1:0] wdata;

  logic               bvalid;
  logic               bready;

  // master: the burst writer (stream sink, AXI write master)
  modport master (
    input  s_valid, s_data,
    output s_ready,
    output awvalid, awaddr, awlen,
    input  awready,
    output wvalid, wlast, wdata,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready,
    input  awvalid, awaddr, awlen,
    output awready,
    input  wvalid, wlast, wdata,
    output wready,
    output bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_stream_burst_writer_fifo.sv
// First-word-fall-through synchronous FIFO with registered pointers.
module sync_fifo_fwft #(
  parameter int DW = 16,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_idx;
  logic [AW-1:0] r_rd_idx;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  // a pop in the same cycle frees the slot a push into a full FIFO needs
  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != CW'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_idx <= r_wr_idx + 1'b1;
      if (w_do_pop)  r_rd_idx <= r_rd_idx + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_idx] <= din;
  end

  assign dout  = r_mem[r_rd_idx];
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/axi_stream_burst_writer.sv
// Buffers a valid/ready word stream and writes it to DDR as AXI bursts at an
// auto-incrementing address; flush drains partial bursts.
//   state | meaning
//   IDLE  | pick next burst (flush remainder first, else a full burst)
//   AW    | address offered, waiting for awready
//   W     | streaming L beats from the FIFO head
//   B     | waiting for the write response
module axi_stream_burst_writer
  import axi_burst_pkg::*;
#(
  parameter int         A_WIDTH   = 25,
  parameter int         D_WIDTH   = 16,
  parameter int         D_LEVEL   = 1,
  parameter logic [7:0] BURST_LEN = 8'd15,
  parameter int         FIFO_AW   = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  base_load,
  input  logic [A_WIDTH-1:0]    base_addr,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  busy,
  output logic [A_WIDTH-1:0]    wr_ptr,
  output logic [15:0]           burst_cnt,
  axi_stream_burst_writer_if.master bus
);
  localparam int            CW       = FIFO_AW + 1;
  localparam logic [CW-1:0] FULL_LEN = CW'(BURST_LEN) + CW'(1);

  state_t               r_state;
  logic                 r_awvalid;
  logic [A_WIDTH-1:0]   r_awaddr;
  logic [7:0]           r_awlen;
  logic [CW-1:0]        r_len;
  logic [CW-1:0]        r_beat;
  logic                 r_wvalid;
  logic                 r_wlast;
  logic                 r_bready;
  logic [CW-1:0]        r_unc;
  logic [CW-1:0]        r_frem;
  logic                 r_factive;
  logic                 r_fdone;
  logic [A_WIDTH-1:0]   r_wr_ptr;
  logic [15:0]          r_burst_cnt;

  logic                 w_full;
  logic                 w_empty;
  logic [CW-1:0]        w_fifo_count;
  logic [D_WIDTH-1:0]   w_dout;
  logic                 w_s_ready;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_aw_hs;
  logic [CW-1:0]        w_unc_next;
  logic                 w_start;
  logic [CW-1:0]        w_start_len;

  sync_fifo_fwft #(.DW(D_WIDTH), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (w_push),
    .din   (bus.s_data),
    .pop   (w_pop),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_fifo_count)
  );

  assign w_s_ready = rstn && !w_full;
  assign w_push    = bus.s_valid && w_s_ready;
  assign w_pop     = r_wvalid && bus.wready;
  assign w_aw_hs   = r_awvalid && bus.awready;

  // words in the FIFO not yet claimed by an issued AW
  assign w_unc_next = r_unc + CW'(w_push) - (w_aw_hs ? r_len : '0);

  assign w_start     = (r_frem != '0) || (r_unc >= FULL_LEN);
  assign w_start_len = (r_frem == '0)     ? FULL_LEN :
                       (r_frem > FULL_LEN) ? FULL_LEN : r_frem;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_awvalid   <= 1'b0;
      r_awaddr    <= '0;
      r_awlen     <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_wvalid    <= 1'b0;
      r_wlast     <= 1'b0;
      r_bready    <= 1'b0;
      r_unc       <= '0;
      r_frem      <= '0;
      r_factive   <= 1'b0;
      r_fdone     <= 1'b0;
      r_wr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_fdone <= 1'b0;
      r_unc   <= w_unc_next;
      if (flush) begin
        r_frem    <= w_unc_next;
        r_factive <= 1'b1;
      end else if (w_aw_hs) begin
        r_frem <= (r_frem > r_len) ? (r_frem - r_len) : '0;
      end

      case (r_state)
        IDLE: begin
          if (base_load) begin
            r_wr_ptr <= base_addr;
          end else if (w_start) begin
            r_len     <= w_start_len;
            r_awlen   <= 8'(w_start_len - CW'(1));
            r_awaddr  <= r_wr_ptr;
            r_awvalid <= 1'b1;
            r_state   <= AW;
          end
          // a fresh flush this cycle re-arms instead of completing
          if (r_factive && (r_frem == '0) && !flush) begin
            r_fdone   <= 1'b1;
            r_factive <= 1'b0;
          end
        end
        AW: begin
          if (bus.awready) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_beat    <= '0;
            r_wlast   <= (r_len == CW'(1));
            r_state   <= W;
          end
        end
        W: begin
          if (bus.wready) begin
            if (r_wlast) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= B;
            end else begin
              r_beat  <= r_beat + CW'(1);
              r_wlast <= ((r_beat + CW'(2)) == r_len);
            end
          end
        end
        B: begin
          if (bus.bvalid) begin
            r_bready    <= 1'b0;
            r_wr_ptr    <= r_wr_ptr + A_WIDTH'(beats_to_bytes(16'(r_len), D_LEVEL));
            r_burst_cnt <= r_burst_cnt + 16'd1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.awvalid = r_awvalid;
  assign bus.awaddr  = r_awaddr;
  assign bus.awlen   = r_awlen;
  assign bus.wvalid  = r_wvalid;
  assign bus.wlast   = r_wlast;
  assign bus.wdata   = (r_wvalid && !w_empty) ? w_dout : '0;
  assign bus.bready  = r_bready;

  assign flush_done = r_fdone;
  assign busy       = (r_state != IDLE) || (w_fifo_count != '0);
  assign wr_ptr     = r_wr_ptr;
  assign burst_cnt  = r_burst_cnt;

endmodule

// File: tb/tb_axi_stream_burst_writer.sv
// Directed bench for axi_stream_burst_writer: table of stream/flush scenarios
// against a behavioural AXI slave, plus reset-mid-burst sequence.
module tb_axi_stream_burst_writer;
  localparam int AWD = 25;
  localparam int DW  = 16;

  logic           clk = 1'b0;
  logic           rstn;
  logic           base_load;
  logic [AWD-1:0] base_addr;
  logic           flush;
  logic           flush_done;
  logic           busy;
  logic [AWD-1:0] wr_ptr;
  logic [15:0]    burst_cnt;

  axi_stream_burst_writer_if #(.A_WIDTH(AWD), .D_WIDTH(DW)) bus_if ();

  axi_stream_burst_writer #(
    .A_WIDTH(AWD), .D_WIDTH(DW), .D_LEVEL(1), .BURST_LEN(8'd15), .FIFO_AW(5)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .base_load  (base_load),
    .base_addr  (base_addr),
    .flush      (flush),
    .flush_done (flush_done),
    .busy       (busy),
    .wr_ptr     (wr_ptr),
    .burst_cnt  (burst_cnt),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           load;
    logic [AWD-1:0] base;
    int             n_push;
    int             fmode;      // 0 none, 1 after pushes, 2 while first burst in W
    logic           slow;
    int             exp_aw;
    logic [AWD-1:0] exp_addr0;
    logic [7:0]     exp_len_last;
    logic [AWD-1:0] exp_ptr;
    logic [15:0]    exp_bc;
    int             exp_fd;
  } vec_t;

  vec_t vecs[7];

  // slave/monitor state (written only by the monitor process)
  logic [DW-1:0]  q_push[$];
  logic [DW-1:0]  q_wd[$];
  logic           q_wl[$];
  logic [AWD-1:0] q_aw_addr[$];
  logic [7:0]     q_aw_len[$];
  int             aw_wait;
  int             occ;
  int             beat_in_burst;
  int             sready_bad;
  int             saw_full;
  int             fdone_cnt;
  bit             pending_b;
  logic [1:0]     wcyc;
  logic [3:0]     wpat = 4'b1001;

  // knobs and scoreboard state (written only by the main process)
  int             aw_delay;
  bit             wtoggle;
  int             n_checks;
  int             n_fail;
  logic [DW-1:0]  word;
  logic [AWD-1:0] model_ptr;
  int             i_push;
  int             i_w;
  int             i_aw;

  always @(negedge clk) begin
    if (!rstn) begin
      bus_if.awready = 1'b0;
      bus_if.wready  = 1'b0;
      bus_if.bvalid  = 1'b0;
      aw_wait = 0; occ = 0; beat_in_burst = 0; pending_b = 1'b0; wcyc = 2'd0;
    end else begin
      if (bus_if.awvalid) begin
        bus_if.awready = (aw_wait >= aw_delay);
        aw_wait++;
      end else begin
        bus_if.awready = 1'b0;
        aw_wait = 0;
      end
      bus_if.wready = wtoggle ? wpat[wcyc] : 1'b1;
      wcyc = wcyc + 2'd1;
      bus_if.bvalid = pending_b;
      #1;
      if (rstn) begin
        if (bus_if.s_ready != (occ < 32)) sready_bad++;
        if (occ == 32 && !bus_if.s_ready) saw_full++;
        if (bus_if.s_valid && bus_if.s_ready) begin
          q_push.push_back(bus_if.s_data);
          occ++;
        end
        if (bus_if.awvalid && bus_if.awready) begin
          q_aw_addr.push_back(bus_if.awaddr);
          q_aw_len.push_back(bus_if.awlen);
        end
        if (bus_if.wvalid && bus_if.wready) begin
          q_wd.push_back(bus_if.wdata);
          q_wl.push_back(bus_if.wlast);
          occ--;
          if (bus_if.wlast) begin
            beat_in_burst = 0;
            pending_b = 1'b1;
          end else begin
            beat_in_burst++;
          end
        end
        if (bus_if.bvalid && bus_if.bready) pending_b = 1'b0;
        if (flush_done) fdone_cnt++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_words(input int n);
    int guard;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus_if.s_valid = 1'b1;
      bus_if.s_data  = word;
      #2;
      guard = 0;
      while (!bus_if.s_ready && guard < 500) begin
        @(negedge clk); #2;
        guard++;
      end
      if (guard >= 500) check("push_timeout", 32'(bus_if.s_ready), 32'd1);
      word = word + 16'd1;
    end
    @(negedge clk);
    bus_if.s_valid = 1'b0;
  endtask

  task automatic apply_vec(input int k);
    vec_t v;
    int   aw0, fd0, n_aw, quiet, cyc, guard;
    logic [AWD-1:0] a;
    logic [7:0]     len;
    string          id;
    v   = vecs[k];
    id  = $sformatf("v%0d", k);
    aw0 = q_aw_addr.size();
    fd0 = fdone_cnt;
    aw_delay = v.slow ? 3 : 0;
    wtoggle  = v.slow;
    if (v.load) begin
      @(negedge clk); base_load = 1'b1; base_addr = v.base;
      @(negedge clk); base_load = 1'b0;
      model_ptr = v.base;
    end
    push_words(v.n_push);
    if (v.fmode == 2) begin
      guard = 0;
      while (!bus_if.wvalid && guard < 200) begin
        @(negedge clk); #2;
        guard++;
      end
      check({id, "_wvalid_before_flush"}, 32'(bus_if.wvalid), 32'd1);
      flush = 1'b1;
      @(negedge clk); flush = 1'b0;
    end else if (v.fmode == 1) begin
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0;
    end
    quiet = 0; cyc = 0;
    while (quiet < 8 && cyc < 4000) begin
      @(negedge clk); #2;
      quiet = busy ? 0 : quiet + 1;
      cyc++;
    end
    check({id, "_settled"}, 32'(quiet >= 8), 32'd1);

    n_aw = q_aw_addr.size() - aw0;
    check({id, "_aw_count"}, 32'(n_aw), 32'(v.exp_aw));
    if (n_aw > 0) check({id, "_awaddr_first"}, 32'(q_aw_addr[aw0]), 32'(v.exp_addr0));
    for (int j = 0; j < n_aw; j++) begin
      a   = q_aw_addr[aw0 + j];
      len = q_aw_len[aw0 + j];
      check($sformatf("%s_b%0d_awaddr", id, j), 32'(a), 32'(model_ptr));
      check($sformatf("%s_b%0d_awlen", id, j), 32'(len),
            (j == n_aw - 1) ? 32'(v.exp_len_last) : 32'd15);
      model_ptr = model_ptr + AWD'((32'(len) + 32'd1) << 1);
      for (int b = 0; b <= int'(len); b++) begin
        if (i_w < q_wd.size() && i_push < q_push.size()) begin
          check($sformatf("%s_b%0d_wdata%0d", id, j, b), 32'(q_wd[i_w]), 32'(q_push[i_push]));
          check($sformatf("%s_b%0d_wlast%0d", id, j, b), 32'(q_wl[i_w]), 32'(b == int'(len)));
        end else begin
          check($sformatf("%s_b%0d_beat%0d_present", id, j, b), 32'd0, 32'd1);
        end
        i_w++;
        i_push++;
      end
    end
    i_aw = q_aw_addr.size();
    check({id, "_extra_w_beats"}, 32'(q_wd.size() - i_w), 32'd0);
    check({id, "_unwritten_words"}, 32'(q_push.size() - i_push), 32'd0);
    check({id, "_wr_ptr"}, 32'(wr_ptr), 32'(v.exp_ptr));
    check({id, "_burst_cnt"}, 32'(burst_cnt), 32'(v.exp_bc));
    check({id, "_flush_done_pulses"}, 32'(fdone_cnt - fd0), 32'(v.exp_fd));
    check({id, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int guard;
    n_checks = 0; n_fail = 0;
    fdone_cnt = 0; sready_bad = 0; saw_full = 0;
    rstn = 1'b0; base_load = 1'b0; base_addr = '0; flush = 1'b0;
    bus_if.s_valid = 1'b0; bus_if.s_data = '0;
    aw_delay = 0; wtoggle = 1'b0; word = '0; model_ptr = '0;
    i_push = 0; i_w = 0; i_aw = 0;

    //          load  base        push fm slow  aw addr0       len    ptr          bc     fd
    vecs[0] = '{1'b1, 25'h0,       16, 0, 1'b0, 1, 25'h0,       8'd15, 25'h20,      16'd1, 0};
    vecs[1] = '{1'b1, 25'h0,        5, 1, 1'b0, 1, 25'h0,       8'd4,  25'h0A,      16'd2, 1};
    vecs[2] = '{1'b1, 25'h0,       64, 0, 1'b1, 4, 25'h0,       8'd15, 25'h80,      16'd6, 0};
    vecs[3] = '{1'b1, 25'h1FFFFE0, 32, 0, 1'b0, 2, 25'h1FFFFE0, 8'd15, 25'h20,      16'd8, 0};
    vecs[4] = '{1'b0, 25'h0,       20, 2, 1'b0, 2, 25'h20,      8'd3,  25'h48,      16'd10, 1};
    vecs[5] = '{1'b0, 25'h0,        0, 1, 1'b0, 0, 25'h0,       8'd0,  25'h48,      16'd10, 1};
    vecs[6] = '{1'b0, 25'h0,       16, 0, 1'b0, 1, 25'h0,       8'd15, 25'h20,      16'd1, 0};

    repeat (3) @(negedge clk);
    #2;
    check("reset_ctrl_outputs",
          32'({bus_if.s_ready, flush_done, bus_if.awvalid, bus_if.wvalid,
               bus_if.wlast, bus_if.bready, busy}), 32'd0);
    check("reset_wr_ptr", 32'(wr_ptr), 32'd0);
    check("reset_burst_cnt", 32'(burst_cnt), 32'd0);
    #1 rstn = 1'b1;
    @(negedge clk); #2;
    check("s_ready_after_reset", 32'(bus_if.s_ready), 32'd1);

    for (int k = 0; k < 6; k++) apply_vec(k);

    // reset in the middle of the 8th W beat
    aw_delay = 0; wtoggle = 1'b0;
    push_words(16);
    guard = 0;
    while (beat_in_burst != 7 && guard < 300) begin
      @(negedge clk); #2;
      guard++;
    end
    check("reach_beat8", 32'(beat_in_burst), 32'd7);
    @(negedge clk); #3;
    rstn = 1'b0;
    #1;
    check("async_reset_ctrl",
          32'({bus_if.s_ready, flush_done, bus_if.awvalid, bus_if.wvalid,
               bus_if.wlast, bus_if.bready, busy}), 32'd0);
    check("async_reset_wr_ptr", 32'(wr_ptr), 32'd0);
    check("async_reset_burst_cnt", 32'(burst_cnt), 32'd0);
    check("async_reset_aw", 32'({bus_if.awlen, bus_if.awaddr[15:0]}), 32'd0);
    check("async_reset_wdata", 32'(bus_if.wdata), 32'd0);
    repeat (2) @(negedge clk);
    #3 rstn = 1'b1;
    i_push = q_push.size(); i_w = q_wd.size(); i_aw = q_aw_addr.size();
    model_ptr = '0;
    @(negedge clk); #2;
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_s_ready", 32'(bus_if.s_ready), 32'd1);
    apply_vec(6);

    check("s_ready_tracks_occupancy", 32'(sready_bad), 32'd0);
    check("fifo_filled_to_32", 32'(saw_full > 0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_stream_burst_writer.md
Name: axi_stream_burst_writer

Overview:
Upstream AXI4 write master for ddr_sdram_ctrl. It accepts a valid/ready word stream and buffers it in an internal FIFO. Full bursts are issued on the controller's AW/W/B channels at an auto-incrementing byte address. A flush request drains partial bursts. The block replaces the self-test master's write half when real data (camera, UART, DMA) has to land in DDR.

Parameters:
A_WIDTH, 25, AXI byte-address width (BA_BITS+ROW_BITS+COL_BITS+DQ_LEVEL-1)
D_WIDTH, 16, AXI data width (8<<D_LEVEL)
D_LEVEL, 1, log2 of bytes per beat
BURST_LEN, 8'd15, awlen of a full burst; a full burst is BURST_LEN+1 beats
FIFO_AW, 5, log2 FIFO depth; depth must be >= 2*(BURST_LEN+1)

Ports:
clk  in  1  single clock, shared with the controller's clk output
rstn  in  1  reset, asynchronous, active-low
base_load  in  1  load base_addr into the write pointer
base_addr  in  A_WIDTH  new write pointer
s_valid  in  1  stream word valid
s_ready  out  1  stream word ready
s_data  in  D_WIDTH  stream word
flush  in  1  pulse: write out all words accepted so far
flush_done  out  1  one-cycle pulse when the flush has completed
busy  out  1  state != IDLE or FIFO non-empty
wr_ptr  out  A_WIDTH  next burst byte address
burst_cnt  out  16  completed bursts, wraps modulo 2^16
awvalid/awready/awaddr[A_WIDTH]/awlen[8]  AXI AW (out/in/out/out)
wvalid/wready/wlast/wdata[D_WIDTH]  AXI W (out/in/out/out)
bvalid/bready  AXI B (in/out)

Behaviour:
- Reset (rstn low, async): FIFO empty; state IDLE; wr_ptr=0; burst_cnt=0; uncommitted=0; flush_rem=0. Outputs s_ready=0, flush_done=0, awvalid=0, wvalid=0, wlast=0, bready=0, busy=0. After reset, s_ready follows "FIFO not full" from the first cycle with rstn high. A reset mid-burst abandons the burst and discards FIFO contents.
- Push: s_valid&&s_ready writes the FIFO, and uncommitted increments by 1.
- FIFO: first-word-fall-through, registered pointers. A simultaneous push and pop is legal when full and when empty+1.
- State machine:
  - IDLE:
    - if flush_rem>0: burst len L = min(BURST_LEN+1, flush_rem) -> AW
    - else if uncommitted >= BURST_LEN+1: L = BURST_LEN+1 -> AW
    - else stay
  - AW: awvalid=1; awaddr=wr_ptr and awlen=L-1 stay stable until awready. On handshake: uncommitted -= L, flush_rem -= L; go to W.
  - W: wvalid = FIFO non-empty (always true, because beats are committed). wdata = FIFO head. wlast=1 on beat index L-1. Each handshake pops one word. The handshake with wlast goes to B.
  - B: bready=1. On bvalid: wr_ptr += L<<D_LEVEL (modulo 2^A_WIDTH, natural wrap); burst_cnt++; go to IDLE.
- One outstanding burst only. The next AW is never asserted before the previous B is accepted. There is at least one IDLE cycle between bursts.
- Flush:
  - A flush in any state sets flush_rem = uncommitted, plus 1 if a push occurs in the same cycle, and sets flush_active.
  - A flush while flush_active re-snapshots flush_rem.
  - When flush_active is set and flush_rem==0 while in IDLE, flush_done pulses for one cycle and flush_active clears. A flush with 0 uncommitted words pulses flush_done on the next IDLE cycle.
- base_load is honoured only in IDLE and takes priority over burst start that cycle; otherwise it is ignored. Partial bursts may leave wr_ptr unaligned. This is legal; the controller accepts any beat-aligned address.
- busy is combinational from state and FIFO empty.

Decomposition:
- Package axi_burst_pkg:
  - state enum {IDLE, AW, W, B}
  - function beats_to_bytes(L, D_LEVEL)
- Sub-module sync_fifo_fwft: params DW and AW; ports clk, rstn, push, din, pop, dout, full, empty, count. It is also reusable as a read-side buffer.

Test Plan:
- Load 0 and push 16 words 0x0000..0x000F -> one AW with awaddr=0 and awlen=15; 16 W beats with data in order; wlast on the 16th; burst_cnt=1; wr_ptr=0x20.
- Push 5 words, then pulse flush -> AW awlen=4; 5 beats; flush_done pulses once after bvalid; wr_ptr=0x0A; busy then 0.
- Continuous push of 64 words with wready toggling 1-0-0-1 and awready delayed 3 cycles -> 4 bursts at 0x00, 0x20, 0x40, 0x60; no data loss or reordering; s_ready drops when the FIFO holds 32 words.
- base_load 0x1FFFFE0 (A_WIDTH=25), push 32 words -> awaddr 0x1FFFFE0 then 0x0000000; wr_ptr=0x20 after both.
- Push 20 words, then flush while the first burst is in W -> second burst awlen=3; flush_done after its B; a flush with an empty FIFO gives a flush_done pulse and no AW.
- rstn low during the 8th W beat -> all outputs 0 asynchronously; FIFO empty; after release, 16 new words produce a clean burst at awaddr 0.
